tdm_demux_4ch: RTL and testbench

TDM_DEMUX_4CH -- requirements
Module: tdm_demux_4ch

---
 rtl/tdm_demux_4ch_if.sv | 41 ++++
 rtl/tdm_demux_4ch.sv | 180 ++++++++++++++++++
 tb/tb_tdm_demux_4ch.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_4ch_if.sv
// tdm_demux_4ch_if
//   Bundles the serial TDM input and the four demultiplexed channel outputs
//   of tdm_demux_4ch.
//   master : drives DIN/FSYNC/EN, observes channel data and status
//   slave  : the demultiplexer itself
//   Signals:
//     DIN       serial data, MSB of each slot first
//     FSYNC     frame sync, high with the MSB of slot 0
//     EN        bit enable, DIN/FSYNC only meaningful when EN=1
//     A,B,C,D   registered slot 0..3 data (SLOT_W bits each)
//     VLD[3:0]  one-cycle new-value strobe per channel
//     SEL[1:0]  slot currently being received
//     LOCK      frame alignment established
//     SYNC_ERR  one-cycle pulse on an out-of-place FSYNC
//     PERR      sticky slot parity error
interface tdm_demux_4ch_if #(
  parameter int SLOT_W = 4
);
  logic              DIN;
  logic              FSYNC;
  logic              EN;
  logic [SLOT_W-1:0] A;
  logic [SLOT_W-1:0] B;
  logic [SLOT_W-1:0] C;
  logic [SLOT_W-1:0] D;
  logic [3:0]        VLD;
  logic [1:0]        SEL;
  logic              LOCK;
  logic              SYNC_ERR;
  logic              PERR;

  modport master (
    output DIN, FSYNC, EN,
    input  A, B, C, D, VLD, SEL, LOCK, SYNC_ERR, PERR
  );

  modport slave (
    input  DIN, FSYNC, EN,
    output A, B, C, D, VLD, SEL, LOCK, SYNC_ERR, PERR
  );
endinterface

// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch
//   Four-channel TDM serial demultiplexer. A frame is four slots of SLOT_W
//   bits (MSB first); FSYNC marks the first bit of slot 0. A two-state
//   HUNT/RUN machine aligns to FSYNC, assembles each slot in a shift
//   register and writes it to channel register A/B/C/D with a one-cycle
//   VLD strobe. A flywheel tolerates one missing FSYNC; two consecutive
//   misses drop back to HUNT. An FSYNC seen off the frame boundary forces a
//   resync and pulses SYNC_ERR.
//   Ports:
//     clk    single clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    tdm_demux_4ch_if.slave (DIN, FSYNC, EN in; A..D, VLD, SEL,
//            LOCK, SYNC_ERR, PERR out)
//   Build option:
//     TDM_DEMUX_PARITY_EN  each slot carries one trailing even-parity bit;
//                          a bad slot is dropped (no write, no VLD) and
//                          sets sticky PERR. Undefined: PERR is tied to 0.
module tdm_demux_4ch #(
  parameter int SLOT_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  tdm_demux_4ch_if.slave  bus
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int SLOT_BITS = SLOT_W + 1;
`else
  localparam int SLOT_BITS = SLOT_W;
`endif
  localparam int CNT_W = $clog2(SLOT_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_BITS - 1);

  typedef enum logic {HUNT, RUN} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt_p0;
  logic [1:0]          sel_p0;
  logic [SLOT_BITS-1:0] shift_p0;
  logic                miss;
  logic                lock_arm;

  logic [SLOT_W-1:0]   a_p1, b_p1, c_p1, d_p1;
  logic [3:0]          vld_p1;
  logic                sync_err;
  logic                lock;
  logic                perr;

  logic [SLOT_BITS-1:0] word_p0;
  logic [SLOT_W-1:0]    data_p0;
  logic                 word_ok;
  logic                 at_boundary;
  logic                 run_bit;
  logic                 restart;
  logic                 drop;
  logic                 slot_done;

`ifdef TDM_DEMUX_PARITY_EN
  function automatic logic even_parity_ok(input logic [SLOT_BITS-1:0] w);
    return ~(^w);
  endfunction
  assign word_ok = even_parity_ok(word_p0);
`else
  assign word_ok = 1'b1;
`endif

  always_comb begin
    word_p0     = {shift_p0[SLOT_BITS-2:0], bus.DIN};
    data_p0     = word_p0[SLOT_BITS-1 -: SLOT_W];
    at_boundary = (sel_p0 == 2'd0) && (cnt_p0 == '0);
    run_bit     = bus.EN && (state == RUN);
    // FSYNC anywhere but the expected frame start forces a resync.
    restart     = run_bit && bus.FSYNC && !at_boundary;
    // Second consecutive missing FSYNC: alignment is lost.
    drop        = run_bit && !bus.FSYNC && at_boundary && miss;
    slot_done   = run_bit && !restart && !drop && (cnt_p0 == LAST_BIT);
  end

  // Stage p0 -> p1: bit assembly, framing control and channel write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      cnt_p0   <= '0;
      sel_p0   <= 2'd0;
      shift_p0 <= '0;
      miss     <= 1'b0;
      lock_arm <= 1'b0;
      a_p1     <= '0;
      b_p1     <= '0;
      c_p1     <= '0;
      d_p1     <= '0;
      vld_p1   <= 4'd0;
      sync_err <= 1'b0;
      lock     <= 1'b0;
    end else begin
      vld_p1   <= 4'd0;
      sync_err <= 1'b0;
      lock_arm <= 1'b0;
      // LOCK follows the VLD[3] that completed the first aligned frame
      // by one cycle; later branches may still clear it.
      if (lock_arm) lock <= 1'b1;

      if (bus.EN) begin
        case (state)
          HUNT: begin
            if (bus.FSYNC) begin
              state    <= RUN;
              shift_p0 <= {{(SLOT_BITS-1){1'b0}}, bus.DIN};
              cnt_p0   <= CNT_W'(1);
              sel_p0   <= 2'd0;
              miss     <= 1'b0;
              lock     <= 1'b0;
            end
          end
          RUN: begin
            if (restart) begin
              // Partial slot is discarded; this bit is the new slot 0 MSB.
              shift_p0 <= {{(SLOT_BITS-1){1'b0}}, bus.DIN};
              cnt_p0   <= CNT_W'(1);
              sel_p0   <= 2'd0;
              miss     <= 1'b0;
              sync_err <= 1'b1;
              lock     <= 1'b0;
            end else if (drop) begin
              state    <= HUNT;
              shift_p0 <= '0;
              cnt_p0   <= '0;
              sel_p0   <= 2'd0;
              miss     <= 1'b0;
              lock     <= 1'b0;
            end else begin
              if (at_boundary) miss <= ~bus.FSYNC;
              shift_p0 <= word_p0;
              if (slot_done) begin
                cnt_p0 <= '0;
                sel_p0 <= sel_p0 + 2'd1;
                if (word_ok) begin
                  case (sel_p0)
                    2'd0:    a_p1 <= data_p0;
                    2'd1:    b_p1 <= data_p0;
                    2'd2:    c_p1 <= data_p0;
                    default: d_p1 <= data_p0;
                  endcase
                  vld_p1[sel_p0] <= 1'b1;
                end
                if (sel_p0 == 2'd3) lock_arm <= 1'b1;
              end else begin
                cnt_p0 <= cnt_p0 + CNT_W'(1);
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr <= 1'b0;
    end else if (slot_done && !word_ok) begin
      perr <= 1'b1;
    end
  end
`else
  assign perr = 1'b0;
`endif

  assign bus.A        = a_p1;
  assign bus.B        = b_p1;
  assign bus.C        = c_p1;
  assign bus.D        = d_p1;
  assign bus.VLD      = vld_p1;
  assign bus.SEL      = sel_p0;
  assign bus.LOCK     = lock;
  assign bus.SYNC_ERR = sync_err;
  assign bus.PERR     = perr;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb_tdm_demux_4ch
//   Directed bench for tdm_demux_4ch with SLOT_W=4. Expected channel writes
//   are queued as each frame is driven and retired by a monitor when VLD
//   fires; status outputs are checked at fixed points of the sequence.
//   Works with or without TDM_DEMUX_PARITY_EN (the parity case is added
//   when the macro is defined).
module tb_tdm_demux_4ch;
  localparam int SW = 4;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int NB = SW + 1;
`else
  localparam int NB = SW;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tdm_demux_4ch_if #(.SLOT_W(SW)) bus ();

  tdm_demux_4ch #(.SLOT_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int            ch;
    logic [SW-1:0] val;
    int            gap;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_vld_cyc = 0;
  logic [SW-1:0] mon_val;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] ch_val(input int i);
    case (i)
      0:       return bus.A;
      1:       return bus.B;
      2:       return bus.C;
      default: return bus.D;
    endcase
  endfunction

  // Retire scoreboard entries as strobes appear.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.VLD !== 4'b0000) begin
      check("vld_onehot", $countones(bus.VLD), 1);
      for (int i = 0; i < 4; i++) begin
        if (bus.VLD[i]) begin
          mon_val = ch_val(i);
          if (sb.size() == 0) begin
            check("vld_unexpected", {28'b0, bus.VLD}, 32'h0);
          end else begin
            mon_e = sb.pop_front();
            check("vld_ch", i, mon_e.ch);
            check("vld_data", mon_val, mon_e.val);
            if (mon_e.gap != 0) check("vld_gap", cyc - last_vld_cyc, mon_e.gap);
          end
          last_vld_cyc = cyc;
        end
      end
    end
  end

  task automatic expect_slot(input int ch, input logic [SW-1:0] v, input int gap);
    exp_t e;
    e.ch = ch; e.val = v; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic tick(input logic d, input logic fs, input logic en);
    bus.DIN = d; bus.FSYNC = fs; bus.EN = en;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB-1:0] slot_bits(input logic [SW-1:0] v, input bit bad);
`ifdef TDM_DEMUX_PARITY_EN
    return {v, (^v) ^ bad};
`else
    return v ^ {SW{bad & 1'b0}};
`endif
  endfunction

  // One slot MSB first; toggle inserts an EN=0 cycle (with junk DIN and
  // FSYNC=1) after every bit.
  task automatic send_slot(input logic [SW-1:0] v, input bit fs_first,
                           input bit toggle, input bit bad);
    logic [NB-1:0] b;
    b = slot_bits(v, bad);
    for (int k = NB - 1; k >= 0; k--) begin
      tick(b[k], fs_first && (k == NB - 1), 1'b1);
      if (toggle) tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, bus.A, 0);
    check({tag, "_b"}, bus.B, 0);
    check({tag, "_c"}, bus.C, 0);
    check({tag, "_d"}, bus.D, 0);
    check({tag, "_vld"}, bus.VLD, 0);
    check({tag, "_sel"}, bus.SEL, 0);
    check({tag, "_lock"}, bus.LOCK, 0);
    check({tag, "_syncerr"}, bus.SYNC_ERR, 0);
    check({tag, "_perr"}, bus.PERR, 0);
  endtask

  initial begin
    logic [NB-1:0] rb;
    rst_n = 1'b0;
    bus.DIN = 1'b0; bus.FSYNC = 1'b0; bus.EN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    // Basic frame A=A, B=5, C=F, D=0
    expect_slot(0, 4'hA, 0);
    expect_slot(1, 4'h5, NB);
    expect_slot(2, 4'hF, NB);
    expect_slot(3, 4'h0, NB);
    send_slot(4'hA, 1, 0, 0);
    check("f1_sel_after_a", bus.SEL, 1);
    send_slot(4'h5, 0, 0, 0);
    send_slot(4'hF, 0, 0, 0);
    send_slot(4'h0, 0, 0, 0);
    check("f1_vld3", bus.VLD, 4'b1000);
    check("f1_lock_at_vld3", bus.LOCK, 0);
    tick(1'b0, 1'b0, 1'b0);
    check("f1_lock_after", bus.LOCK, 1);
    check("f1_a", bus.A, 4'hA);
    check("f1_b", bus.B, 4'h5);
    check("f1_c", bus.C, 4'hF);
    check("f1_d", bus.D, 4'h0);

    // Same frame with EN toggling; FSYNC at the expected boundary
    expect_slot(0, 4'hA, 0);
    expect_slot(1, 4'h5, 2 * NB);
    expect_slot(2, 4'hF, 2 * NB);
    expect_slot(3, 4'h0, 2 * NB);
    send_slot(4'hA, 1, 1, 0);
    check("f2_syncerr", bus.SYNC_ERR, 0);
    send_slot(4'h5, 0, 1, 0);
    send_slot(4'hF, 0, 1, 0);
    send_slot(4'h0, 0, 1, 0);
    check("f2_lock", bus.LOCK, 1);
    check("f2_c", bus.C, 4'hF);
    check("f2_qempty", sb.size(), 0);

    // Out-of-place FSYNC at slot 2 bit 1
    expect_slot(0, 4'h3, 0);
    expect_slot(1, 4'hC, NB);
    send_slot(4'h3, 1, 0, 0);
    send_slot(4'hC, 0, 0, 0);
    tick(1'b0, 1'b0, 1'b1);
    rb = slot_bits(4'h9, 0);
    tick(rb[NB-1], 1'b1, 1'b1);
    check("rs_syncerr", bus.SYNC_ERR, 1);
    check("rs_lock", bus.LOCK, 0);
    check("rs_sel", bus.SEL, 0);
    check("rs_c_held", bus.C, 4'hF);
    expect_slot(0, 4'h9, 0);
    for (int k = NB - 2; k >= 0; k--) begin
      tick(rb[k], 1'b0, 1'b1);
      if (k == NB - 2) check("rs_syncerr_off", bus.SYNC_ERR, 0);
    end
    expect_slot(1, 4'h2, NB);
    expect_slot(2, 4'h7, NB);
    expect_slot(3, 4'hE, NB);
    send_slot(4'h2, 0, 0, 0);
    check("rs_lock_mid", bus.LOCK, 0);
    send_slot(4'h7, 0, 0, 0);
    send_slot(4'hE, 0, 0, 0);
    check("rs_lock_at_vld3", bus.LOCK, 0);
    tick(1'b0, 1'b0, 1'b0);
    check("rs_lock_after", bus.LOCK, 1);
    check("rs_c", bus.C, 4'h7);

    // Flywheel: first missing FSYNC keeps receiving, second drops to HUNT
    expect_slot(0, 4'h1, 0);
    expect_slot(1, 4'h2, NB);
    expect_slot(2, 4'h4, NB);
    expect_slot(3, 4'h8, NB);
    send_slot(4'h1, 0, 0, 0);
    check("fw_lock_miss1", bus.LOCK, 1);
    send_slot(4'h2, 0, 0, 0);
    send_slot(4'h4, 0, 0, 0);
    send_slot(4'h8, 0, 0, 0);
    tick(1'b1, 1'b0, 1'b1);
    check("fw_lock_miss2", bus.LOCK, 0);
    check("fw_sel", bus.SEL, 0);
    for (int s = 0; s < 4; s++) send_slot(4'hF, 0, 0, 0);
    check("fw_hunt_sel", bus.SEL, 0);
    check("fw_hunt_a", bus.A, 4'h1);
    check("fw_hunt_d", bus.D, 4'h8);
    check("fw_qempty", sb.size(), 0);

    // Asynchronous reset mid-slot 1
    expect_slot(0, 4'h5, 0);
    send_slot(4'h5, 1, 0, 0);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 2 * NB; k++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    check("arst_sel", bus.SEL, 0);
    check("arst_qempty", sb.size(), 0);
    expect_slot(0, 4'h6, 0);
    expect_slot(1, 4'h7, NB);
    expect_slot(2, 4'h8, NB);
    expect_slot(3, 4'h9, NB);
    send_slot(4'h6, 1, 0, 0);
    send_slot(4'h7, 0, 0, 0);
    send_slot(4'h8, 0, 0, 0);
    send_slot(4'h9, 0, 0, 0);
    tick(1'b0, 1'b0, 1'b0);
    check("arst_relock", bus.LOCK, 1);

`ifdef TDM_DEMUX_PARITY_EN
    // Slot 0 = 1010 with parity bit 1 (bad)
    expect_slot(1, 4'hB, 0);
    expect_slot(2, 4'hC, NB);
    expect_slot(3, 4'hD, NB);
    send_slot(4'hA, 1, 0, 1);
    check("par_perr", bus.PERR, 1);
    check("par_a_held", bus.A, 4'h6);
    send_slot(4'hB, 0, 0, 0);
    send_slot(4'hC, 0, 0, 0);
    send_slot(4'hD, 0, 0, 0);
    expect_slot(0, 4'h3, 0);
    send_slot(4'h3, 1, 0, 0);
    check("par_perr_held", bus.PERR, 1);
    check("par_a_new", bus.A, 4'h3);
`else
    check("noparity_perr", bus.PERR, 0);
`endif

    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check("final_qempty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
